// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared state and fetch-source types for the IFU miss controller
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        FILL
    } t_miss_ctrl_state;

    typedef enum logic {
        SRC_MISS,
        SRC_PF
    } t_fetch_src;

endpackage

// File: rtl/ifu_miss_ctrl_if.sv
// rtl/ifu_miss_ctrl_if.sv - request, memory and fill signals of the IFU miss controller
interface ifu_miss_ctrl_if #(
    parameter int TAG_WIDTH  = 28,
    parameter int LINE_WIDTH = 128
);
    logic                  miss_reqValidIn;
    logic [TAG_WIDTH-1:0]  miss_reqTagIn;
    logic                  miss_reqReadyOut;
    logic                  pf_reqValidIn;
    logic [TAG_WIDTH-1:0]  pf_reqTagIn;
    logic                  pf_reqReadyOut;
    logic                  mem_reqValidOut;
    logic [TAG_WIDTH-1:0]  mem_reqTagOut;
    logic                  mem_reqReadyIn;
    logic                  mem_rspValidIn;
    logic [TAG_WIDTH-1:0]  mem_rspTagIn;
    logic [LINE_WIDTH-1:0] mem_rspInsLineIn;
    logic                  fill_validOut;
    logic [TAG_WIDTH-1:0]  fill_tagOut;
    logic [LINE_WIDTH-1:0] fill_lineOut;
    logic                  fill_isPfOut;
    logic                  timeoutErrOut;
    logic                  busyOut;

    // master is the controller's view; slave is the cache/memory environment
    modport master (
        input  miss_reqValidIn, miss_reqTagIn, pf_reqValidIn, pf_reqTagIn,
               mem_reqReadyIn, mem_rspValidIn, mem_rspTagIn, mem_rspInsLineIn,
        output miss_reqReadyOut, pf_reqReadyOut, mem_reqValidOut, mem_reqTagOut,
               fill_validOut, fill_tagOut, fill_lineOut, fill_isPfOut,
               timeoutErrOut, busyOut
    );

    modport slave (
        output miss_reqValidIn, miss_reqTagIn, pf_reqValidIn, pf_reqTagIn,
               mem_reqReadyIn, mem_rspValidIn, mem_rspTagIn, mem_rspInsLineIn,
        input  miss_reqReadyOut, pf_reqReadyOut, mem_reqValidOut, mem_reqTagOut,
               fill_validOut, fill_tagOut, fill_lineOut, fill_isPfOut,
               timeoutErrOut, busyOut
    );

endinterface

// File: rtl/ifu_miss_ctrl.sv
// rtl/ifu_miss_ctrl.sv - single-outstanding line fetch sequencer (prefetch path under IFU_PREFETCH_EN)
module ifu_miss_ctrl
    import ifu_pkg::*;
#(
    parameter int TAG_WIDTH  = 28,
    parameter int LINE_WIDTH = 128,
    parameter int MAX_WAIT   = 64
) (
    input logic             Clock,
    input logic             Rst,
    ifu_miss_ctrl_if.master bus
);

    localparam int                CNT_W    = $clog2(MAX_WAIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_WAIT - 1);

    t_miss_ctrl_state      state;
    t_fetch_src            src;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic [CNT_W-1:0]      cnt;
    logic [TAG_WIDTH-1:0]  fill_tag_q;
    logic [LINE_WIDTH-1:0] fill_line_q;
    logic                  fill_ispf_q;
    logic                  timeout_q;

    logic pf_valid;
    logic pf_ready;
    logic promote;
    logic rsp_hit;
    logic fill_is_pf;

`ifdef IFU_PREFETCH_EN
    assign pf_valid = bus.pf_reqValidIn;
    assign pf_ready = !Rst && (state == IDLE) && !bus.miss_reqValidIn;
`else
    logic unused_pf;
    assign unused_pf = ^{bus.pf_reqValidIn, bus.pf_reqTagIn, fill_ispf_q};
    assign pf_valid  = 1'b0;
    assign pf_ready  = 1'b0;
`endif

    // A demand miss for the line already being prefetched rides on that fetch
    assign promote = !Rst && (state != IDLE) && (src == SRC_PF) &&
                     bus.miss_reqValidIn && (bus.miss_reqTagIn == tag_q);

    assign rsp_hit    = bus.mem_rspValidIn && (bus.mem_rspTagIn == tag_q);
    assign fill_is_pf = (src == SRC_PF) && !promote;

    assign bus.miss_reqReadyOut = !Rst && ((state == IDLE) || promote);
    assign bus.pf_reqReadyOut   = pf_ready;
    assign bus.mem_reqValidOut  = (state == REQ);
    assign bus.mem_reqTagOut    = tag_q;
    assign bus.fill_validOut    = (state == FILL);
    assign bus.fill_tagOut      = fill_tag_q;
    assign bus.fill_lineOut     = fill_line_q;
    assign bus.timeoutErrOut    = timeout_q;
    assign bus.busyOut          = (state != IDLE);

`ifdef IFU_PREFETCH_EN
    assign bus.fill_isPfOut = (state == FILL) ? fill_is_pf : fill_ispf_q;
`else
    assign bus.fill_isPfOut = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Rst) begin
            state       <= IDLE;
            src         <= SRC_MISS;
            tag_q       <= '0;
            cnt         <= '0;
            fill_tag_q  <= '0;
            fill_line_q <= '0;
            fill_ispf_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (promote) begin
                src <= SRC_MISS;
            end
            case (state)
                IDLE: begin
                    if (bus.miss_reqValidIn) begin
                        tag_q <= bus.miss_reqTagIn;
                        src   <= SRC_MISS;
                        state <= REQ;
                    end else if (pf_valid) begin
                        tag_q <= bus.pf_reqTagIn;
                        src   <= SRC_PF;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_reqReadyIn) begin
                        cnt   <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // a matching response in the final wait cycle still wins over abort
                    if (rsp_hit) begin
                        fill_tag_q  <= tag_q;
                        fill_line_q <= bus.mem_rspInsLineIn;
                        state       <= FILL;
                    end else if (cnt == CNT_LAST) begin
                        timeout_q <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FILL: begin
                    fill_ispf_q <= fill_is_pf;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
